usb_rx_bit_unstuff: RTL and testbench
=====================================

# usb_rx_bit_unstuff

Receive-path bit unstuffer between the NRZI decoder and the CRC16 decode/check stage. Accepts one decoded bit per `in_valid` cycle, deletes the stuffed 0 inserted after every run of MAX_ONES consecutive 1s, and forwards the remaining data bits as a registered valid/bit stream. It flags stuffing violations, counts forwarded bits, and emits a single-cycle end-of-packet pulse to the CRC stage.

## Interface
Parameters:
- MAX_ONES, 6, run length of 1s after which the next bit must be a stuffed 0
- CNT_W, 16, width of `bit_count`

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rx_start  in  1  one-cycle pulse after SYNC; begins a packet
- in_valid  in  1  `in_bit` holds a decoded bit this cycle
- in_bit  in  1  NRZI-decoded bit
- in_eop  in  1  one-cycle pulse: SE0/EOP detected
- out_valid  out  1  `out_bit` is a data bit; drives the CRC stage's sending/enable input
- out_bit  out  1  unstuffed data bit
- pkt_done  out  1  one-cycle pulse: packet ended
- stuff_err  out  1  stuffing violation in current/last packet; sticky until next `rx_start`
- bit_count  out  CNT_W  data bits forwarded in current packet

## Operation
- States: IDLE, RECV, DROP, ERR. Internal `ones` counter, 0..MAX_ONES.
- Priority each cycle: `rx_start` > `in_eop` > `in_valid`.
- `rx_start` in any state: next state RECV; `ones`=0, `bit_count`=0, `stuff_err`=0. A simultaneous `in_valid` bit is discarded. No `pkt_done` for an aborted packet.
- IDLE: `in_valid`, `in_eop` ignored.
- RECV, `in_valid`:
  - `in_bit`=0: forward, `ones`=0.
  - `in_bit`=1: forward, `ones`+1; on reaching MAX_ONES, `ones`=0 and go to DROP.
- DROP, `in_valid`:
  - `in_bit`=0: stuffed bit, not forwarded; go to RECV.
  - `in_bit`=1: not forwarded; `stuff_err`=1; go to ERR.
- ERR: `in_valid` ignored, nothing forwarded.
- `in_eop` in RECV or ERR: `pkt_done` pulse, go to IDLE.
- `in_eop` in DROP: pending stuffed 0 missing; `stuff_err`=1, `pkt_done` pulse, go to IDLE.
- `in_eop` in IDLE: ignored, no pulse.
- A bit arriving with `in_eop` in the same cycle is discarded.
- `bit_count` increments once per forwarded bit and saturates at all-ones (no wrap).
- `stuff_err` and `bit_count` hold their values through IDLE until the next `rx_start`.

## Timing
- Reset: state IDLE, `ones`=0; `out_valid`=0, `out_bit`=0, `pkt_done`=0, `stuff_err`=0, `bit_count`=0.
- All outputs registered.
- Latency: bit sampled at edge N appears on `out_valid`/`out_bit` for exactly one cycle after edge N. `out_valid` is low otherwise, and `out_bit` holds its last value.
- `pkt_done` is high one cycle after the edge sampling `in_eop`. `stuff_err` is valid no later than that same cycle.
- `bit_count` updates on the same edge that asserts `out_valid` for that bit.
- `in_valid` may be high on consecutive cycles or gapped. No backpressure: the downstream stage consumes every `out_valid` cycle.
- Asynchronous reset mid-packet returns to reset values immediately. No `pkt_done`.

## Test plan
- Rx_start, then 8 bits 1,0,1,1,0,0,1,0, then in_eop -> 8 out_valid pulses with identical bits, bit_count=8, pkt_done one cycle after in_eop, stuff_err=0.
- Bits 1×6, 0, 1, then in_eop -> 7 forwarded bits (six 1s, then 1); the 0 is dropped; bit_count=7, stuff_err=0.
- Bits 1×7 -> six forwarded, 7th not forwarded, stuff_err=1. Further bits ignored until in_eop; then pkt_done, bit_count=6.
- Bits 1×6, then in_eop -> six forwarded, stuff_err=1, pkt_done asserted.
- Gapped stream (in_valid every 3rd cycle) of 0x00 with rx_start mid-packet after 4 bits -> bit_count resets to 0, no pkt_done, new packet counted from 0.
- Same-cycle in_valid+in_eop, and in_eop while IDLE -> bit not forwarded; in IDLE no pkt_done, no state change.

Source files
------------

// File: rtl/usb_rx_bit_unstuff.sv
// USB receive-path bit unstuffer.
// Drops stuffed zeros, flags violations, counts data bits.
module usb_rx_bit_unstuff #(
  parameter int MAX_ONES = 6,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rx_start,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_eop,
  output logic             out_valid,
  output logic             out_bit,
  output logic             pkt_done,
  output logic             stuff_err,
  output logic [CNT_W-1:0] bit_count
);

  localparam int OW = $clog2(MAX_ONES + 1);
  localparam logic [OW-1:0] LAST = OW'(MAX_ONES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP,
    ERR
  } state_t;

  state_t        state;
  logic [OW-1:0] ones;
  logic          cnt_sat;

  assign cnt_sat = &bit_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ones      <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      pkt_done  <= 1'b0;
      stuff_err <= 1'b0;
      bit_count <= '0;
    end else begin
      out_valid <= 1'b0;
      pkt_done  <= 1'b0;
      if (rx_start) begin
        state     <= RECV;
        ones      <= '0;
        bit_count <= '0;
        stuff_err <= 1'b0;
      end else if (in_eop) begin
        case (state)
          RECV, ERR: begin
            pkt_done <= 1'b1;
            state    <= IDLE;
            ones     <= '0;
          end
          // EOP while a stuffed zero is still owed
          DROP: begin
            stuff_err <= 1'b1;
            pkt_done  <= 1'b1;
            state     <= IDLE;
            ones      <= '0;
          end
          default: ;
        endcase
      end else if (in_valid) begin
        case (state)
          RECV: begin
            out_valid <= 1'b1;
            out_bit   <= in_bit;
            if (!cnt_sat)
              bit_count <= bit_count + 1'b1;
            if (!in_bit) begin
              ones <= '0;
            end else if (ones == LAST) begin
              ones  <= '0;
              state <= DROP;
            end else begin
              ones <= ones + 1'b1;
            end
          end
          DROP: begin
            if (in_bit) begin
              stuff_err <= 1'b1;
              state     <= ERR;
            end else begin
              state <= RECV;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_bit_unstuff.sv
// Self-checking bench for usb_rx_bit_unstuff.
// Directed packets plus randomized traffic against a model.
module tb_usb_rx_bit_unstuff;

  localparam int MAX_ONES = 6;
  localparam int CNT_W    = 5;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset_n;
  logic             rx_start;
  logic             in_valid;
  logic             in_bit;
  logic             in_eop;
  logic             out_valid;
  logic             out_bit;
  logic             pkt_done;
  logic             stuff_err;
  logic [CNT_W-1:0] bit_count;

  int checks;
  int failures;

  usb_rx_bit_unstuff #(
    .MAX_ONES(MAX_ONES),
    .CNT_W   (CNT_W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx_start (rx_start),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_eop   (in_eop),
    .out_valid(out_valid),
    .out_bit  (out_bit),
    .pkt_done (pkt_done),
    .stuff_err(stuff_err),
    .bit_count(bit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // model: packet open, run of ones, stuff owed, dead after error
  bit m_active;
  bit m_pend;
  bit m_dead;
  bit m_err;
  int m_run;
  int m_cnt;
  bit e_valid;
  bit e_bit;
  bit e_done;

  int fwd_n;
  int fwd_v;
  int done_n;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    e_valid = 1'b0;
    e_done  = 1'b0;
    if (!reset_n) begin
      m_active = 0;
      m_pend   = 0;
      m_dead   = 0;
      m_err    = 0;
      m_run    = 0;
      m_cnt    = 0;
      e_bit    = 0;
    end else if (rx_start) begin
      m_active = 1;
      m_pend   = 0;
      m_dead   = 0;
      m_err    = 0;
      m_run    = 0;
      m_cnt    = 0;
    end else if (in_eop) begin
      if (m_active) begin
        if (m_pend) m_err = 1;
        e_done   = 1;
        m_active = 0;
        m_pend   = 0;
        m_run    = 0;
      end
    end else if (in_valid && m_active && !m_dead) begin
      if (m_pend) begin
        m_pend = 0;
        if (in_bit) begin
          m_err  = 1;
          m_dead = 1;
        end
      end else begin
        e_valid = 1;
        e_bit   = in_bit;
        if (m_cnt < CMAX) m_cnt++;
        m_run = in_bit ? m_run + 1 : 0;
        if (m_run == MAX_ONES) begin
          m_run  = 0;
          m_pend = 1;
        end
      end
    end
    #1;
    chk("out_valid", int'(out_valid), int'(e_valid));
    chk("out_bit", int'(out_bit), int'(e_bit));
    chk("pkt_done", int'(pkt_done), int'(e_done));
    chk("stuff_err", int'(stuff_err), int'(m_err));
    chk("bit_count", int'(bit_count), m_cnt);
    if (out_valid) begin
      fwd_n++;
      fwd_v = (fwd_v << 1) | int'(out_bit);
    end
    if (pkt_done) done_n++;
  end

  task automatic cyc(bit s, bit v, bit b, bit e);
    @(negedge clock);
    rx_start = s;
    in_valid = v;
    in_bit   = b;
    in_eop   = e;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic clr();
    @(negedge clock);
    fwd_n  = 0;
    fwd_v  = 0;
    done_n = 0;
  endtask

  task automatic send(int n, bit b);
    for (int i = 0; i < n; i++) cyc(0, 1, b, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    fwd_n    = 0;
    fwd_v    = 0;
    done_n   = 0;
    rx_start = 0;
    in_valid = 0;
    in_bit   = 0;
    in_eop   = 0;
    reset_n  = 0;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_count", int'(bit_count), 0);
    idle(2);
    reset_n = 1;
    idle(2);

    // plain 8-bit packet
    clr();
    cyc(1, 0, 0, 0);
    begin
      logic [7:0] pat;
      pat = 8'b10110010;
      for (int i = 7; i >= 0; i--) cyc(0, 1, pat[i], 0);
    end
    cyc(0, 0, 0, 1);
    idle(2);
    chk("t1_fwd_n", fwd_n, 8);
    chk("t1_bits", fwd_v, 'hB2);
    chk("t1_count", int'(bit_count), 8);
    chk("t1_done", done_n, 1);
    chk("t1_err", int'(stuff_err), 0);

    // six ones, stuffed zero, one
    clr();
    cyc(1, 0, 0, 0);
    send(6, 1);
    send(1, 0);
    send(1, 1);
    cyc(0, 0, 0, 1);
    idle(2);
    chk("t2_fwd_n", fwd_n, 7);
    chk("t2_bits", fwd_v, 'h7F);
    chk("t2_count", int'(bit_count), 7);
    chk("t2_err", int'(stuff_err), 0);

    // seven ones: violation, rest ignored
    clr();
    cyc(1, 0, 0, 0);
    send(7, 1);
    send(1, 0);
    send(2, 1);
    cyc(0, 0, 0, 1);
    idle(2);
    chk("t3_fwd_n", fwd_n, 6);
    chk("t3_count", int'(bit_count), 6);
    chk("t3_err", int'(stuff_err), 1);
    chk("t3_done", done_n, 1);

    // six ones then EOP: owed zero missing
    clr();
    cyc(1, 0, 0, 0);
    send(6, 1);
    cyc(0, 0, 0, 1);
    idle(2);
    chk("t4_fwd_n", fwd_n, 6);
    chk("t4_err", int'(stuff_err), 1);
    chk("t4_done", done_n, 1);

    // gapped zeros, restart mid-packet
    clr();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0);
      idle(2);
    end
    cyc(1, 1, 0, 0);
    #2;
    chk("t5_restart", int'(bit_count), 4);
    for (int i = 0; i < 5; i++) begin
      idle(2);
      cyc(0, 1, 0, 0);
    end
    idle(1);
    chk("t5_done_none", done_n, 0);
    chk("t5_count", int'(bit_count), 5);
    cyc(0, 0, 0, 1);
    idle(2);
    chk("t5_done", done_n, 1);

    // bit with EOP dropped; IDLE ignores EOP and bits
    clr();
    cyc(1, 0, 0, 0);
    send(1, 0);
    cyc(0, 1, 1, 1);
    idle(2);
    chk("t6_fwd_n", fwd_n, 1);
    chk("t6_done", done_n, 1);
    clr();
    cyc(0, 0, 0, 1);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 1);
    idle(2);
    chk("t6_idle_done", done_n, 0);
    chk("t6_idle_fwd", fwd_n, 0);
    chk("t6_idle_count", int'(bit_count), 1);

    // saturation of the count
    clr();
    cyc(1, 0, 0, 0);
    send(CMAX + 5, 0);
    cyc(0, 0, 0, 1);
    idle(2);
    chk("sat_count", int'(bit_count), CMAX);

    // asynchronous reset mid-packet
    clr();
    cyc(1, 0, 0, 0);
    send(3, 1);
    @(negedge clock);
    reset_n = 0;
    #1;
    chk("arst_count", int'(bit_count), 0);
    chk("arst_done", int'(pkt_done), 0);
    chk("arst_valid", int'(out_valid), 0);
    idle(2);
    reset_n = 1;
    idle(1);

    // randomized packets
    for (int p = 0; p < 60; p++) begin
      cyc(1, $urandom_range(0, 1), 1, 0);
      for (int i = 0; i < $urandom_range(0, 45); i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 25)
          cyc(0, 0, 0, 0);
        else if (r < 27)
          cyc(0, $urandom_range(0, 1), 1, 1);
        else if (r < 28)
          cyc(1, $urandom_range(0, 1), 0, 0);
        else
          cyc(0, 1, $urandom_range(0, 9) < 8, 0);
      end
      if ($urandom_range(0, 4) != 0)
        cyc(0, $urandom_range(0, 1), 1, 1);
      for (int i = 0; i < $urandom_range(0, 4); i++)
        cyc(0, $urandom_range(0, 1), 1,
            $urandom_range(0, 3) == 0);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
